pdata_seq: RTL and testbench

//  Upstream sequencer for one pdata serial MAC element. Accepts parallel operand pairs over a

---
 rtl/pdata_seq.sv | 164 ++++++++++++++++
 tb/tb_pdata_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pdata_seq.sv
// pdata_seq: upstream sequencer for one pdata serial MAC element.
// Serialises an operand pair into pdata with LOAD, issues MUL or MUL_ADD,
// and optionally shifts the accumulator out with OUT_RES into a parallel word.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE. res_valid
// stays high and res_data stays stable until res_ready is seen high.
module pdata_seq #(
    parameter  int SIZE  = 32,
    localparam int CNT_W = $clog2(4*SIZE+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_data1,
    input  logic [SIZE-1:0]   in_data2,
    input  logic              in_accum,
    input  logic              in_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4*SIZE-1:0] res_data,
    output logic [2:0]        opcode,
    output logic              rx,
    input  logic              tx
);

    localparam logic [2:0] OP_OUT_RES = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_MUL_ADD = 3'd6;
    localparam logic [2:0] OP_NO_OP   = 3'd7;

    // Last counter values of the LOAD and READ phases.
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(2*SIZE-1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(4*SIZE-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_READ,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          opcode_q, opcode_d;
    logic                rx_q, rx_d;
    logic [2*SIZE-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accum_q, accum_d;
    logic                last_q, last_d;
    logic [4*SIZE-1:0]   res_shift_q, res_shift_d;
    logic                res_valid_q, res_valid_d;

    // State and datapath registers; reset clears everything to the idle picture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            opcode_q    <= OP_NO_OP;
            rx_q        <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            accum_q     <= 1'b0;
            last_q      <= 1'b0;
            res_shift_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            rx_q        <= rx_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            accum_q     <= accum_d;
            last_q      <= last_d;
            res_shift_q <= res_shift_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state and next-output logic; opcode/rx are computed one cycle ahead
    // so pdata sees registered values on the edge that consumes them.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        rx_d        = 1'b0;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        accum_d     = accum_q;
        last_d      = last_q;
        res_shift_d = res_shift_q;
        res_valid_d = res_valid_q;
        in_ready    = (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                opcode_d = OP_NO_OP;
                if (in_valid) begin
                    // MSB of in_data2 goes out now; the register keeps the rest
                    // already shifted so each LOAD edge just takes the top bit.
                    rx_d     = in_data2[SIZE-1];
                    shreg_d  = {in_data2[SIZE-2:0], in_data1, 1'b0};
                    accum_d  = in_accum;
                    last_d   = in_last;
                    cnt_d    = '0;
                    opcode_d = OP_LOAD;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d    = '0;
                    opcode_d = accum_q ? OP_MUL_ADD : OP_MUL;
                    state_d  = S_EXEC;
                end else begin
                    rx_d    = shreg_q[2*SIZE-1];
                    shreg_d = {shreg_q[2*SIZE-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                cnt_d = '0;
                if (last_q) begin
                    opcode_d = OP_OUT_RES;
                    state_d  = S_READ;
                end else begin
                    // pdata keeps its accumulator for a following MUL_ADD.
                    opcode_d = OP_NO_OP;
                    state_d  = S_IDLE;
                end
            end
            S_READ: begin
                // tx carries acc LSB-first; fill from the top so the word
                // ends up LSB-aligned after all 4*SIZE edges.
                res_shift_d = {tx, res_shift_q[4*SIZE-1:1]};
                if (cnt_q == READ_LAST) begin
                    cnt_d       = '0;
                    opcode_d    = OP_NO_OP;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                opcode_d = OP_NO_OP;
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                opcode_d = OP_NO_OP;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign opcode    = opcode_q;
    assign rx        = rx_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_shift_q;

endmodule

// File: tb/tb_pdata_seq.sv
// Bench for pdata_seq (SIZE=8) with a behavioural pdata element attached.
module tb_pdata_seq;

  localparam int S  = 8;
  localparam int RW = 4*S;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [S-1:0]  in_data1 = '0;
  logic [S-1:0]  in_data2 = '0;
  logic          in_accum = 1'b0;
  logic          in_last  = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [RW-1:0] res_data;
  logic [2:0]    opcode;
  logic          rx;
  logic          tx;

  pdata_seq #(.SIZE(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2),
    .in_accum(in_accum), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .opcode(opcode), .rx(rx), .tx(tx)
  );

  // ---------------- behavioural pdata element ----------------
  logic [S-1:0]  pd_d1, pd_d2;
  logic [RW-1:0] pd_acc;
  always @(posedge clk) begin
    if (rst) begin
      pd_d1 <= '0; pd_d2 <= '0; pd_acc <= '0;
    end else begin
      case (opcode)
        3'd3: {pd_d2, pd_d1} <= {pd_d2[S-2:0], pd_d1, rx};
        3'd5: pd_acc <= {{(RW-S){1'b0}}, pd_d1} * {{(RW-S){1'b0}}, pd_d2};
        3'd6: pd_acc <= pd_acc + {{(RW-S){1'b0}}, pd_d1} * {{(RW-S){1'b0}}, pd_d2};
        3'd2: pd_acc <= pd_acc >> 1;
        default: ;
      endcase
    end
  end
  assign tx = (opcode == 3'd2) ? pd_acc[0] : 1'bz;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rx_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: pops one expected word per accepted result.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", res_data, '0);
      end else begin
        check("res_data", res_data, exp_q.pop_front());
      end
    end
  end

  // rx must be 0 outside LOAD and opcode never unknown once out of reset.
  always @(negedge clk) begin
    if (!rst && ((opcode != 3'd3 && rx !== 1'b0) || ^opcode === 1'bx)) rx_bad++;
  end

  // ---------------- driver tasks ----------------
  int acc_cyc;

  task automatic send(input logic [S-1:0] d1, input logic [S-1:0] d2,
                      input logic acc, input logic last);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) check("send_timeout", 0, 1);
    in_data1 = d1; in_data2 = d2; in_accum = acc; in_last = last;
    in_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1 in_valid = 1'b0;
  endtask

  // Samples each negedge after the accept edge (k=0 is right after it).
  task automatic watch(input bit want_res, output int load_n, output int res_k,
                       output int rdy_k, output logic [15:0] rx_pat);
    load_n = 0; res_k = -1; rdy_k = -1; rx_pat = '0;
    for (int k = 0; k <= 200; k++) begin
      @(negedge clk);
      if (opcode == 3'd3) begin load_n++; rx_pat = {rx_pat[14:0], rx}; end
      if (in_ready && rdy_k < 0) rdy_k = k;
      if (res_valid && res_k < 0) res_k = k;
      if (want_res ? (res_k >= 0) : (rdy_k >= 0)) break;
    end
    if (want_res ? (res_k < 0) : (rdy_k < 0)) check("watch_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !res_valid && exp_q.size() == 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) check("idle_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  int ld, rk, yk, a0;
  logic [15:0] pat;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_opcode", opcode, 7);
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_rx", rx, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 3*5, readout
    exp_q.push_back(15);
    send(3, 5, 0, 1);
    watch(1, ld, rk, yk, pat);
    check("t1_load_cycles", ld, 16);
    check("t1_res_latency", rk, 49);
    wait_idle();

    // 2: 3*5 then +7*11 -> 92; back-to-back acceptance
    exp_q.push_back(92);
    send(3, 5, 0, 0);
    a0 = acc_cyc;
    watch(0, ld, rk, yk, pat);
    check("t2_ready_rise", yk, 17);
    send(7, 11, 1, 1);
    check("t2_accept_spacing", acc_cyc - a0, 18);
    watch(1, ld, rk, yk, pat);
    wait_idle();

    // 3: 255*255, rx pattern during LOAD
    exp_q.push_back(65025);
    send(255, 255, 0, 1);
    watch(1, ld, rk, yk, pat);
    check("t3_rx_pattern", pat, 16'hFFFF);
    wait_idle();

    // 4: consumer stall in DONE, with a pair offered meanwhile
    exp_q.push_back(15);
    res_ready = 1'b0;
    send(3, 5, 0, 1);
    watch(1, ld, rk, yk, pat);
    in_data1 = 100; in_data2 = 100; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_res_valid", res_valid, 1);
      check("t4_res_data", res_data, 15);
      check("t4_in_ready", in_ready, 0);
      check("t4_opcode", opcode, 7);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();

    // 5: reset in the middle of LOAD, then a fresh op
    send(9, 9, 0, 1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_opcode", opcode, 7);
    check("t5_in_ready", in_ready, 1);
    check("t5_res_valid", res_valid, 0);
    exp_q.push_back(18);
    send(2, 9, 0, 1);
    watch(1, ld, rk, yk, pat);
    wait_idle();

    // 6: in_valid held with changing operands while busy
    exp_q.push_back(42);
    send(6, 7, 0, 1);
    for (int k = 0; k < 200; k++) begin
      in_valid = 1'b1;
      in_data1 = S'($urandom_range(0, 255));
      in_data2 = S'($urandom_range(0, 255));
      in_accum = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (res_valid) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    check("rx_or_opcode_violations", rx_bad, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
